// File: rtl/ps2_host_tx_if.sv
// Host-side request/response bundle for the PS/2 host transmitter.
// The master drives a byte and request; the slave (transmitter) reports ready/done/error.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_done,
        input  tx_error
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_done,
        output tx_error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send and
// clocks out one odd-parity frame on device-generated clock edges, then checks the ACK.
module ps2_host_tx #(
    parameter int CLK_FREQ          = 28_000_000,
    parameter int INHIBIT_US        = 100,
    parameter int FIRST_TIMEOUT_US  = 15000,
    parameter int PACKET_TIMEOUT_US = 2000
) (
    input  logic            clk28,
    input  logic            rst_n,
    input  logic            ps2_clk_in,
    input  logic            ps2_dat_in,
    output logic            ps2_clk_oe,
    output logic            ps2_dat_oe,
    output logic            rx_inhibit,
    ps2_host_tx_if.slave    tx
);
    localparam int DIV = CLK_FREQ / 1_000_000;
    localparam int PW  = $clog2(DIV + 1);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_INHIBIT    = 4'd1;
    localparam logic [3:0] S_START      = 4'd2;
    localparam logic [3:0] S_WAIT_FIRST = 4'd3;
    localparam logic [3:0] S_BITS       = 4'd4;
    localparam logic [3:0] S_ACK        = 4'd5;
    localparam logic [3:0] S_WAIT_IDLE  = 4'd6;
    localparam logic [3:0] S_DONE       = 4'd7;
    localparam logic [3:0] S_ERR        = 4'd8;

    logic [2:0]    r_clk_sync;
    logic [2:0]    r_dat_sync;
    logic [PW-1:0] r_pre;
    logic [13:0]   r_us_cnt;
    logic [13:0]   r_pkt_cnt;
    logic [3:0]    r_state;
    logic [7:0]    r_sh;
    logic          r_parity;
    logic [3:0]    r_bitcnt;
    logic          r_dat_drv;

    logic [3:0]    w_state_next;
    logic          w_fe;
    logic          w_tick;
    logic          w_accept;
    logic          w_pkt_timeout;
    logic          w_clk_s;
    logic          w_dat_s;

    // Index [2] is the oldest stage: a falling edge is "was high, now low".
    assign w_fe          = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_clk_s       = r_clk_sync[2];
    assign w_dat_s       = r_dat_sync[2];
    assign w_tick        = (r_pre == PW'(DIV - 1));
    assign w_accept      = tx.tx_valid && (r_state == S_IDLE);
    assign w_pkt_timeout = (r_pkt_cnt > 14'(PACKET_TIMEOUT_US));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:       if (w_accept) w_state_next = S_INHIBIT;
            S_INHIBIT:    if (r_us_cnt >= 14'(INHIBIT_US)) w_state_next = S_START;
            S_START:      if (w_tick) w_state_next = S_WAIT_FIRST;
            S_WAIT_FIRST: begin
                if (r_us_cnt >= 14'(FIRST_TIMEOUT_US)) w_state_next = S_ERR;
                else if (w_fe)                         w_state_next = S_BITS;
            end
            S_BITS: begin
                if (w_pkt_timeout)                    w_state_next = S_ERR;
                else if (w_fe && r_bitcnt == 4'd9)    w_state_next = S_ACK;
            end
            S_ACK: begin
                if (w_pkt_timeout) w_state_next = S_ERR;
                else if (w_fe)     w_state_next = w_dat_s ? S_ERR : S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (w_pkt_timeout)         w_state_next = S_ERR;
                else if (w_clk_s && w_dat_s) w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            S_ERR:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync <= 3'b111;
            r_dat_sync <= 3'b111;
            r_pre      <= '0;
        end else begin
            r_clk_sync <= {r_clk_sync[1:0], ps2_clk_in};
            r_dat_sync <= {r_dat_sync[1:0], ps2_dat_in};
            r_pre      <= w_tick ? '0 : r_pre + 1'b1;
        end
    end

    // Both counters saturate so a long stay in any state can never wrap into a false match.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            r_us_cnt  <= '0;
            r_pkt_cnt <= '0;
        end else begin
            if (w_state_next != r_state || w_fe)
                r_us_cnt <= '0;
            else if (w_tick && r_us_cnt != 14'h3FFF)
                r_us_cnt <= r_us_cnt + 1'b1;

            if (r_state == S_IDLE || r_state == S_WAIT_FIRST)
                r_pkt_cnt <= '0;
            else if (w_tick && r_pkt_cnt != 14'h3FFF)
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_sh      <= '0;
            r_parity  <= 1'b0;
            r_bitcnt  <= '0;
            r_dat_drv <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_sh     <= tx.tx_data;
                r_parity <= ~^tx.tx_data;
                r_bitcnt <= '0;
            end
            if (r_state == S_WAIT_FIRST && w_state_next == S_BITS) begin
                r_dat_drv <= ~r_sh[0];
                r_bitcnt  <= 4'd1;
            end else if (r_state == S_BITS && w_fe && !w_pkt_timeout) begin
                if (r_bitcnt <= 4'd7)      r_dat_drv <= ~r_sh[r_bitcnt[2:0]];
                else if (r_bitcnt == 4'd8) r_dat_drv <= ~r_parity;
                else                       r_dat_drv <= 1'b0;
                r_bitcnt <= r_bitcnt + 1'b1;
            end
        end
    end

    // Line enables decode straight from state so an async reset frees the bus at once.
    assign ps2_clk_oe  = (r_state == S_INHIBIT) || (r_state == S_START);
    assign ps2_dat_oe  = (r_state == S_START) || (r_state == S_WAIT_FIRST) ||
                         ((r_state == S_BITS) && r_dat_drv);
    assign rx_inhibit  = (r_state != S_IDLE);
    assign tx.tx_ready = (r_state == S_IDLE);
    assign tx.tx_done  = (r_state == S_DONE);
    assign tx.tx_error = (r_state == S_ERR);
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a cycle-level PS/2 device model drives the shared open-collector
// lines; a frame table plus hand-written timeout and reset sequences check the host.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int HP = 40;    // device clock half period in clk28 cycles (4 MHz bench clock)

    logic clk28 = 1'b0;
    logic rst_n;
    logic ps2_clk_oe, ps2_dat_oe, rx_inhibit;
    logic dev_clk_low, dev_dat_low;
    logic ps2_clk_in, ps2_dat_in;

    ps2_host_tx_if txi ();

    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .CLK_FREQ(4_000_000), .INHIBIT_US(100),
        .FIRST_TIMEOUT_US(300), .PACKET_TIMEOUT_US(400)
    ) dut (
        .clk28(clk28), .rst_n(rst_n),
        .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe),
        .rx_inhibit(rx_inhibit), .tx(txi)
    );

    always #10 clk28 = ~clk28;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    always @(negedge clk28) begin
        if (txi.tx_done)  done_cnt++;
        if (txi.tx_error) err_cnt++;
        if (txi.tx_done && txi.tx_error) both_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk28);
        txi.tx_data  = d;
        txi.tx_valid = 1'b1;
        @(negedge clk28);
        txi.tx_valid = 1'b0;
    endtask

    // Waits for the request-to-send, then generates n_edges clock pulses, sampling data on rising edges.
    task automatic dev_run(input int n_edges, input bit ack_low, output logic [9:0] bits,
                           output int inh_cycles, output bit got_req, output logic start_lvl);
        int t;
        bits = '0; inh_cycles = 0; t = 0; start_lvl = 1'b1;
        while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1 && inh_cycles > 0) && t < 5000) begin
            if (ps2_clk_oe) inh_cycles++;
            @(negedge clk28);
            t++;
        end
        got_req = (t < 5000);
        if (!got_req) return;
        start_lvl = ps2_dat_in;
        if (n_edges == 0) return;
        repeat (20) @(negedge clk28);
        for (int k = 1; k <= n_edges; k++) begin
            dev_clk_low = 1'b1;
            repeat (HP) @(negedge clk28);
            if (k <= 10) bits[k-1] = ps2_dat_in;
            dev_clk_low = 1'b0;
            if (k == 11) dev_dat_low = 1'b0;
            if (k == 10) begin
                repeat (HP/2) @(negedge clk28);
                dev_dat_low = ack_low;
                repeat (HP/2) @(negedge clk28);
            end else begin
                repeat (HP) @(negedge clk28);
            end
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_result(input int d0, input int e0);
        int t;
        t = 0;
        while (done_cnt == d0 && err_cnt == e0 && t < 3000) begin
            @(negedge clk28);
            t++;
        end
        repeat (10) @(negedge clk28);
    endtask

    typedef struct {
        logic [7:0] data;
        int         edges;
        bit         ack_low;
        int         exp_done;
        int         exp_err;
        bit         chk_bits;
        logic [9:0] exp_bits;    // {stop, parity, data[7:0]} as seen on the line
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [9:0] bits;
        int inh, d0, e0, t;
        bit req;
        logic st;

        vecs[0] = '{8'hED, 11, 1'b1, 1, 0, 1'b1, 10'h3ED};
        vecs[1] = '{8'h01, 11, 1'b1, 1, 0, 1'b1, 10'h201};
        vecs[2] = '{8'h00, 11, 1'b1, 1, 0, 1'b1, 10'h300};
        vecs[3] = '{8'hFF, 11, 1'b1, 1, 0, 1'b1, 10'h3FF};
        vecs[4] = '{8'hA5, 11, 1'b1, 1, 0, 1'b1, 10'h3A5};
        vecs[5] = '{8'h3C, 11, 1'b0, 0, 1, 1'b1, 10'h33C};
        vecs[6] = '{8'h55,  5, 1'b1, 0, 1, 1'b0, 10'h000};

        rst_n = 1'b0; txi.tx_valid = 1'b0; txi.tx_data = 8'h00;
        dev_clk_low = 1'b0; dev_dat_low = 1'b0;
        repeat (3) @(negedge clk28);
        chk("rst_clk_oe", int'(ps2_clk_oe), 0);
        chk("rst_dat_oe", int'(ps2_dat_oe), 0);
        chk("rst_ready", int'(txi.tx_ready), 1);
        chk("rst_done", int'(txi.tx_done), 0);
        chk("rst_error", int'(txi.tx_error), 0);
        chk("rst_inhibit", int'(rx_inhibit), 0);
        $display("reset: clk_oe=%0d dat_oe=%0d ready=%0d inhibit=%0d", ps2_clk_oe, ps2_dat_oe, txi.tx_ready, rx_inhibit);
        rst_n = 1'b1;
        repeat (5) @(negedge clk28);

        foreach (vecs[i]) begin
            d0 = done_cnt; e0 = err_cnt;
            send(vecs[i].data);
            dev_run(vecs[i].edges, vecs[i].ack_low, bits, inh, req, st);
            chk("request_seen", int'(req), 1);
            chk("start_bit", int'(st), 0);
            chk_range("inhibit_cycles", inh, 390, 410);
            wait_result(d0, e0);
            chk("done_pulses", done_cnt - d0, vecs[i].exp_done);
            chk("error_pulses", err_cnt - e0, vecs[i].exp_err);
            if (vecs[i].chk_bits) chk("frame_bits", int'(bits), int'(vecs[i].exp_bits));
            chk("ready_after", int'(txi.tx_ready), 1);
            chk("lines_after", int'({ps2_clk_oe, ps2_dat_oe}), 0);
            chk("inhibit_after", int'(rx_inhibit), 0);
            $display("tx 0x%02h edges=%0d ack_low=%0d: inhibit=%0d bits=0x%03h done=%0d err=%0d",
                     vecs[i].data, vecs[i].edges, vecs[i].ack_low, inh, bits, done_cnt - d0, err_cnt - e0);
        end

        // No device: error must arrive 300 us (1200 cycles) after the clock line is released.
        d0 = done_cnt; e0 = err_cnt;
        send(8'hF0);
        dev_run(0, 1'b1, bits, inh, req, st);
        t = 0;
        while (!txi.tx_error && t < 3000) begin
            @(negedge clk28);
            t++;
        end
        chk_range("first_timeout_cycles", t, 1192, 1208);
        repeat (5) @(negedge clk28);
        chk("first_timeout_err", err_cnt - e0, 1);
        chk("first_timeout_done", done_cnt - d0, 0);
        chk("first_timeout_lines", int'({ps2_clk_oe, ps2_dat_oe, rx_inhibit}), 0);
        $display("tx 0xF0 no device: error after %0d cycles", t);

        // Reset mid-frame: busy request ignored, lines freed asynchronously, next request accepted.
        send(8'h00);
        dev_run(3, 1'b1, bits, inh, req, st);
        chk("bits_dat_driven", int'(ps2_dat_oe), 1);
        @(negedge clk28);
        txi.tx_data = 8'h77; txi.tx_valid = 1'b1;
        @(negedge clk28);
        txi.tx_valid = 1'b0;
        repeat (4) @(negedge clk28);
        chk("busy_valid_ignored", int'({ps2_clk_oe, rx_inhibit}), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_lines", int'({ps2_clk_oe, ps2_dat_oe}), 0);
        chk("async_rst_inhibit", int'(rx_inhibit), 0);
        chk("async_rst_ready", int'(txi.tx_ready), 1);
        @(negedge clk28);
        rst_n = 1'b1;
        d0 = done_cnt; e0 = err_cnt;
        txi.tx_data = 8'h5A; txi.tx_valid = 1'b1;
        @(negedge clk28);
        txi.tx_valid = 1'b0;
        chk("post_rst_accept", int'(ps2_clk_oe), 1);
        dev_run(11, 1'b1, bits, inh, req, st);
        wait_result(d0, e0);
        chk("post_rst_bits", int'(bits), 10'h35A);
        chk("post_rst_done", done_cnt - d0, 1);
        $display("reset mid-frame then tx 0x5A: bits=0x%03h done=%0d err=%0d", bits, done_cnt - d0, err_cnt - e0);

        chk("done_and_error_together", both_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
